// File: rtl/ssd_scan.sv
// Time-multiplexed scan driver for a common-anode seven-segment display.
// Each digit slot is a blanking gap followed by the lit period. Displayed data
// is swapped only at frame start, so one frame never mixes old and new values.
module ssd_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    lz_en,
    output logic [3:0]              digit,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VW    = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;

    logic [VW-1:0]     pending_reg, pending_next;
    logic              pend_vld_reg, pend_vld_next;
    logic [VW-1:0]     active_reg, active_next;

    logic [3:0]            digit_reg, digit_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic                  frame_tick_reg, frame_tick_next;

    logic                  frame_start;
    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] zero_above;
    logic                  suppress;

    // First cycle of digit 0's blanking gap is the frame boundary.
    assign frame_start = (state_reg == BLANK) && (cnt_reg == '0) && (idx_reg == '0);

    // Split the value being shown into nibbles and flag digits whose nibble
    // and everything more significant is zero (leading-zero candidates).
    // Outputs are built from next-cycle values, so look at active_next.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi]        = active_next[4*gi +: 4];
            assign zero_above[gi] = (active_next[VW-1:4*gi] == '0);
        end
    endgenerate

    // Pending/active data path: loads park in pending, promoted at frame start.
    always_comb begin
        pending_next  = pending_reg;
        pend_vld_next = pend_vld_reg;
        active_next   = active_reg;
        if (load) begin
            pending_next = value;
        end
        if (frame_start) begin
            if (load) begin
                active_next = value;
            end else if (pend_vld_reg) begin
                active_next = pending_reg;
            end
            pend_vld_next = 1'b0;
        end else if (load) begin
            pend_vld_next = 1'b1;
        end
    end

    // Scan FSM next-state: slot counter, digit index, blank/show phases.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
                BLANK: begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(BLANK_CYCLES - 1)) begin
                        state_next = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_reg == CNT_W'(PRESCALE - 1)) begin
                        cnt_next   = '0;
                        state_next = BLANK;
                        if (idx_reg == IDX_W'(NUM_DIGITS - 1)) begin
                            idx_next = '0;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Output decode from next-cycle state so the registered outputs line up
    // with the state they describe.
    always_comb begin
        suppress        = lz_en && (idx_next != '0) && zero_above[idx_next];
        an_next         = '1;
        digit_next      = 4'h0;
        frame_tick_next = (state_next == BLANK) && (cnt_next == '0) && (idx_next == '0);
        if (state_next != IDLE) begin
            digit_next = nib[idx_next];
        end
        if ((state_next == SHOW) && !suppress) begin
            an_next[idx_next] = 1'b0;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    // Display data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg  <= '0;
            pend_vld_reg <= 1'b0;
            active_reg   <= '0;
        end else begin
            pending_reg  <= pending_next;
            pend_vld_reg <= pend_vld_next;
            active_reg   <= active_next;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_reg         <= '1;
            digit_reg      <= 4'h0;
            frame_tick_reg <= 1'b0;
        end else begin
            an_reg         <= an_next;
            digit_reg      <= digit_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign an         = an_reg;
    assign digit      = digit_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_ssd_scan.sv
// Bench for ssd_scan: per-cycle expected anode/digit/frame_tick values are
// queued from a frame model and compared at the falling edge.
module tb_ssd_scan;

    localparam int ND = 4;
    localparam int PS = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * PS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = 16'h0;
    logic          lz_en = 1'b0;
    logic [3:0]    digit;
    logic [ND-1:0] an;
    logic          frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] dig;
        logic       chk;
        logic       ft;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;

    ssd_scan #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
        .lz_en(lz_en), .digit(digit), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Model of one frame position p (0..FRAME-1) for a displayed value.
    task automatic push_range(input logic [15:0] v, input logic lz, input int p0, input int p1);
        for (int p = p0; p <= p1; p++) begin
            int idx;
            int cnt;
            logic [15:0] upper;
            logic lit;
            exp_t x;
            idx   = p / PS;
            cnt   = p % PS;
            upper = v >> (4 * idx);
            lit   = (cnt >= BC) && !(lz && idx > 0 && upper == 16'h0);
            x.an  = lit ? ~(4'b0001 << idx) : 4'b1111;
            x.dig = upper[3:0];
            x.chk = lit;
            x.ft  = (p == 0);
            sb.push_back(x);
        end
    endtask

    task automatic push_idle(input int n);
        exp_t x;
        x.an = 4'b1111; x.dig = 4'h0; x.chk = 1'b1; x.ft = 1'b0;
        repeat (n) sb.push_back(x);
    endtask

    // Advance to the next falling edge and pop that cycle's expectation.
    task automatic tick_pop();
        @(negedge clk);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no entry, required one queued");
            e = '{an: 4'b1111, dig: 4'h0, chk: 1'b0, ft: 1'b0};
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b required 1111", an); end
        n_checks++; if (digit !== 4'h0) begin n_fail++; $display("FAIL reset_digit: got %h required 0", digit); end
        n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_ft: got %b required 0", frame_tick); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        push_idle(20);
        for (int c = 0; c < 20; c++) begin
            tick_pop();
            n_checks++; if (an !== e.an) begin n_fail++; $display("FAIL idle_an c=%0d: got %b required %b", c, an, e.an); end
            n_checks++; if (frame_tick !== e.ft) begin n_fail++; $display("FAIL idle_ft c=%0d: got %b required %b", c, frame_tick, e.ft); end
            if (c == 0) begin load = 1'b1; value = 16'h1234; $display("load 1234 while idle"); end
            if (c == 1) load = 1'b0;
        end
    endtask

    task automatic test_scan();
        en = 1'b1;
        push_range(16'h1234, 1'b0, 0, FRAME-1);
        push_range(16'h1234, 1'b0, 0, FRAME-1);
        for (int c = 0; c < 2*FRAME; c++) begin
            tick_pop();
            n_checks++; if (an !== e.an) begin n_fail++; $display("FAIL scan_an c=%0d: got %b required %b", c, an, e.an); end
            n_checks++; if (frame_tick !== e.ft) begin n_fail++; $display("FAIL scan_ft c=%0d: got %b required %b", c, frame_tick, e.ft); end
            if (e.chk) begin
                n_checks++; if (digit !== e.dig) begin n_fail++; $display("FAIL scan_digit c=%0d: got %h required %h", c, digit, e.dig); end
            end
        end
        $display("scan of 1234 over two frames done");
    endtask

    task automatic test_frame_update();
        push_range(16'h1234, 1'b0, 0, FRAME-1);
        push_range(16'hABCD, 1'b0, 0, FRAME-1);
        for (int c = 0; c < 2*FRAME; c++) begin
            tick_pop();
            n_checks++; if (an !== e.an) begin n_fail++; $display("FAIL upd_an c=%0d: got %b required %b", c, an, e.an); end
            n_checks++; if (frame_tick !== e.ft) begin n_fail++; $display("FAIL upd_ft c=%0d: got %b required %b", c, frame_tick, e.ft); end
            if (e.chk) begin
                n_checks++; if (digit !== e.dig) begin n_fail++; $display("FAIL upd_digit c=%0d: got %h required %h", c, digit, e.dig); end
            end
            if (c == 17) begin load = 1'b1; value = 16'hABCD; $display("load ABCD mid-frame at idx 2"); end
            if (c == 18) load = 1'b0;
        end
    endtask

    task automatic test_load_at_tick();
        push_range(16'h00F0, 1'b0, 0, FRAME-1);
        for (int c = 0; c < FRAME; c++) begin
            tick_pop();
            n_checks++; if (an !== e.an) begin n_fail++; $display("FAIL tick_an c=%0d: got %b required %b", c, an, e.an); end
            n_checks++; if (frame_tick !== e.ft) begin n_fail++; $display("FAIL tick_ft c=%0d: got %b required %b", c, frame_tick, e.ft); end
            if (e.chk) begin
                n_checks++; if (digit !== e.dig) begin n_fail++; $display("FAIL tick_digit c=%0d: got %h required %h", c, digit, e.dig); end
            end
            if (c == 0) begin load = 1'b1; value = 16'h00F0; $display("load 00F0 on frame_tick"); end
            if (c == 1) load = 1'b0;
        end
        n_checks++; if (dut.pend_vld_reg !== 1'b0) begin n_fail++; $display("FAIL tick_pend_vld: got %b required 0", dut.pend_vld_reg); end
    endtask

    task automatic test_lz();
        push_range(16'h0050, 1'b1, 0, FRAME-1);
        push_range(16'h0000, 1'b1, 0, FRAME-1);
        for (int c = 0; c < 2*FRAME; c++) begin
            tick_pop();
            n_checks++; if (an !== e.an) begin n_fail++; $display("FAIL lz_an c=%0d: got %b required %b", c, an, e.an); end
            n_checks++; if (frame_tick !== e.ft) begin n_fail++; $display("FAIL lz_ft c=%0d: got %b required %b", c, frame_tick, e.ft); end
            if (e.chk) begin
                n_checks++; if (digit !== e.dig) begin n_fail++; $display("FAIL lz_digit c=%0d: got %h required %h", c, digit, e.dig); end
            end
            if (c == 0) begin load = 1'b1; value = 16'h0050; lz_en = 1'b1; $display("load 0050 with lz_en"); end
            if (c == 1) load = 1'b0;
            if (c == 15) begin load = 1'b1; value = 16'h0000; $display("load 0000 with lz_en"); end
            if (c == 16) load = 1'b0;
        end
    endtask

    task automatic test_en_drop();
        push_range(16'h1234, 1'b0, 0, 20);
        push_idle(5);
        push_range(16'h1234, 1'b0, 0, FRAME-1);
        for (int c = 0; c < 26 + FRAME; c++) begin
            tick_pop();
            n_checks++; if (an !== e.an) begin n_fail++; $display("FAIL endrop_an c=%0d: got %b required %b", c, an, e.an); end
            n_checks++; if (frame_tick !== e.ft) begin n_fail++; $display("FAIL endrop_ft c=%0d: got %b required %b", c, frame_tick, e.ft); end
            if (e.chk) begin
                n_checks++; if (digit !== e.dig) begin n_fail++; $display("FAIL endrop_digit c=%0d: got %h required %h", c, digit, e.dig); end
            end
            if (c == 0) begin load = 1'b1; value = 16'h1234; lz_en = 1'b0; $display("load 1234 on frame_tick"); end
            if (c == 1) load = 1'b0;
            if (c == 20) begin en = 1'b0; $display("en dropped in SHOW of digit 2"); end
            if (c == 25) begin en = 1'b1; $display("en raised again"); end
        end
    endtask

    task automatic test_async_rst();
        push_range(16'h1234, 1'b0, 0, 11);
        for (int c = 0; c < 12; c++) begin
            tick_pop();
            n_checks++; if (an !== e.an) begin n_fail++; $display("FAIL prerst_an c=%0d: got %b required %b", c, an, e.an); end
            if (e.chk) begin
                n_checks++; if (digit !== e.dig) begin n_fail++; $display("FAIL prerst_digit c=%0d: got %h required %h", c, digit, e.dig); end
            end
        end
        #2 rst = 1'b1;
        $display("async reset pulse mid-scan");
        #1;
        n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL arst_an: got %b required 1111", an); end
        n_checks++; if (digit !== 4'h0) begin n_fail++; $display("FAIL arst_digit: got %h required 0", digit); end
        n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL arst_ft: got %b required 0", frame_tick); end
        n_checks++; if (dut.active_reg !== 16'h0) begin n_fail++; $display("FAIL arst_active: got %h required 0000", dut.active_reg); end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_frame_update();
        test_load_at_tick();
        test_lz();
        test_en_drop();
        test_async_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
